// File: rtl/bitop_pkg.sv
// Shared definitions for the bitwise-op scheduler: opcode values and FSM state encoding.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package bitop_pkg;

  // Opcode carried on req_op, one bit per requester.
  localparam logic OP_OR  = 1'b0;
  localparam logic OP_AND = 1'b1;

  // Scheduler sequence: accept one request, compute, then hold the result
  // until it is consumed.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage : bitop_pkg

// File: rtl/bitop_unit.sv
// Registered bitwise AND/OR unit; y updates only on cycles with en high.
// Latency: 1 cycle from en to y.
// Backpressure: none; y holds its value while en is low.
//
// Ports:
//   clock, reset_n : rising-edge clock, async active-low reset (y -> 0)
//   en             : capture the result of op(a, b) on this edge
//   op             : OP_OR or OP_AND
//   a, b           : WIDTH-bit operands
//   y              : WIDTH-bit registered result
module bitop_unit
  import bitop_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             en,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      y <= '0;
    end else if (en) begin
      y <= (op == OP_AND) ? (a & b) : (a | b);
    end
  end

endmodule : bitop_unit

// File: rtl/bitop_sched.sv
// Round-robin scheduler sharing one registered AND/OR unit among NREQ requesters.
// Latency: request seen -> accept edge -> compute edge; rsp_valid after 2 edges, issue every >=3 cycles.
// Backpressure: rsp_valid/data/id hold until rsp_ready; no new request is accepted meanwhile.
//
// Ports:
//   clock, reset_n      : rising-edge clock, async active-low reset
//   req_valid/req_ready : per-requester handshake; req_ready is one-hot or zero
//   req_op              : per-requester opcode (OP_OR / OP_AND)
//   req_a, req_b        : packed operands, requester k at [k*WIDTH +: WIDTH]
//   rsp_valid/rsp_ready : result handshake
//   rsp_data, rsp_id    : bitwise result and index of the requester it belongs to
module bitop_sched
  import bitop_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int NREQ  = 4,
  parameter int IDW   = 2
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ-1:0]       req_op,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_data,
  output logic [IDW-1:0]        rsp_id
);

  state_t           state;
  state_t           state_nxt;

  // ptr is the last granted index; it starts at NREQ-1 so requester 0
  // comes first after reset.
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   id_q;
  logic             op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;

  // armed stays low until the first edge after reset release so that no
  // grant is offered while reset is still being removed.
  logic             armed;

  logic             gnt_any;
  logic [IDW-1:0]   gnt_idx;
  logic [NREQ-1:0]  gnt_oh;
  logic             sel_op;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic             xfer;
  logic             unit_en;

  // ------------------------------------------------------------------
  // Round-robin pick: the lowest valid index above ptr wins; if there is
  // none, wrap around and take the lowest valid index at or below ptr.
  // The two passes together scan ptr+1, ptr+2, ... mod NREQ.
  // ------------------------------------------------------------------
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (!gnt_any && req_valid[j] && (j > int'(ptr))) begin
        gnt_any = 1'b1;
        gnt_idx = IDW'(j);
      end
    end
    for (int j = 0; j < NREQ; j++) begin
      if (!gnt_any && req_valid[j] && (j <= int'(ptr))) begin
        gnt_any = 1'b1;
        gnt_idx = IDW'(j);
      end
    end
  end

  always_comb begin
    gnt_oh = '0;
    for (int j = 0; j < NREQ; j++) begin
      gnt_oh[j] = gnt_any && (gnt_idx == IDW'(j));
    end
  end

  // Operand select for the winner; gnt_oh has at most one bit set.
  always_comb begin
    sel_op = OP_OR;
    sel_a  = '0;
    sel_b  = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (gnt_oh[j]) begin
        sel_op = req_op[j];
        sel_a  = req_a[j*WIDTH +: WIDTH];
        sel_b  = req_b[j*WIDTH +: WIDTH];
      end
    end
  end

  // ------------------------------------------------------------------
  // FSM
  // ------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    xfer      = 1'b0;
    unit_en   = 1'b0;
    req_ready = '0;
    rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        if (armed && gnt_any) begin
          xfer      = 1'b1;
          req_ready = gnt_oh;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        unit_en   = 1'b1;
        state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // Request capture: operands are frozen at the accept edge so the
  // requester may change req_* freely afterwards. id_q only changes on
  // accept, which keeps rsp_id stable through RESP.
  // ------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr   <= IDW'(NREQ - 1);
      id_q  <= '0;
      op_q  <= OP_OR;
      a_q   <= '0;
      b_q   <= '0;
      armed <= 1'b0;
    end else begin
      armed <= 1'b1;
      if (xfer) begin
        ptr  <= gnt_idx;
        id_q <= gnt_idx;
        op_q <= sel_op;
        a_q  <= sel_a;
        b_q  <= sel_b;
      end
    end
  end

  assign rsp_id = id_q;

  bitop_unit #(
    .WIDTH (WIDTH)
  ) u_unit (
    .clock   (clock),
    .reset_n (reset_n),
    .en      (unit_en),
    .op      (op_q),
    .a       (a_q),
    .b       (b_q),
    .y       (rsp_data)
  );

endmodule : bitop_sched
